// File: rtl/pyc_mem_arb_pkg.sv
// Shared helpers for the pyc_mem_arbiter slice: width helpers and the
// round-robin pick function used by both arbiters.
package pyc_mem_arb_pkg;

   // Widest requester count rr_pick handles; arbiters zero-extend into it.
   localparam int unsigned RR_MAX = 64;
   localparam int unsigned RR_IW  = 6;

   // Index width with a floor of one bit so NUM_REQ = 1 still has a field.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned strb_width(input int unsigned dw);
      return dw / 8;
   endfunction

   // One-hot grant of the first valid requester scanning ptr, ptr+1, ... mod n.
   function automatic logic [RR_MAX-1:0] rr_pick(
      input logic [RR_MAX-1:0] valid,
      input int unsigned       ptr,
      input int unsigned       n
   );
      logic [RR_MAX-1:0] grant;
      logic              found;
      int unsigned       idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < RR_MAX; k++) begin
         if (k < n && !found) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (valid[idx[RR_IW-1:0]]) begin
               grant[idx[RR_IW-1:0]] = 1'b1;
               found                 = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/pyc_mem_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant from valid and a
// registered priority pointer that moves past the last winner.
module pyc_rr_arbiter
   import pyc_mem_arb_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = clog2_min1(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  valid,
   output logic [N-1:0]  ready,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_next_ptr;

   // grant the first valid requester at or after the pointer
   always_comb begin
      ready = N'(rr_pick(RR_MAX'(valid), 32'(r_ptr), N));
   end

   // encode the one-hot grant and the pointer value following it
   always_comb begin
      grant_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (ready[i]) grant_idx = IW'(i);
      end
      w_next_ptr = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
   end

   // pointer advances only on a transfer; ready implies valid
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (|ready) begin
         r_ptr <= w_next_ptr;
      end
   end

endmodule

// File: rtl/pyc_mem_arbiter.sv
// Shares one 1R1W synchronous memory among NUM_REQ requesters with
// independent read and write round-robin arbitration and one-cycle
// read response routing.
module pyc_mem_arbiter
   import pyc_mem_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned ADDR_WIDTH = 64,
   parameter  int unsigned DATA_WIDTH = 64,
   localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH),
   localparam int unsigned IW         = clog2_min1(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            rd_req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_addr,
   output logic [NUM_REQ-1:0]            rd_req_ready,
   output logic [NUM_REQ-1:0]            rd_rsp_valid,
   output logic [DATA_WIDTH-1:0]         rd_rsp_data,
   input  logic [NUM_REQ-1:0]            wr_req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_req_data,
   input  logic [NUM_REQ*STRB_WIDTH-1:0] wr_req_strb,
   output logic [NUM_REQ-1:0]            wr_req_ready,
   output logic                          mem_ren,
   output logic [ADDR_WIDTH-1:0]         mem_raddr,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic                          mem_wvalid,
   output logic [ADDR_WIDTH-1:0]         mem_waddr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   output logic [STRB_WIDTH-1:0]         mem_wstrb
);

   logic [IW-1:0] w_rd_idx;
   logic [IW-1:0] w_wr_idx;
   logic          r_rsp_pend;
   logic [IW-1:0] r_rsp_id;

   pyc_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (rd_req_valid),
      .ready     (rd_req_ready),
      .grant_idx (w_rd_idx)
   );

   pyc_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (wr_req_valid),
      .ready     (wr_req_ready),
      .grant_idx (w_wr_idx)
   );

   // read issue: address of the granted requester, zero when idle
   always_comb begin
      mem_ren   = |rd_req_valid;
      mem_raddr = '0;
      if (|rd_req_ready) begin
         mem_raddr = rd_req_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // write issue: addr/data/strobe of the granted requester, zero when idle
   always_comb begin
      mem_wvalid = |wr_req_valid;
      mem_waddr  = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      if (|wr_req_ready) begin
         mem_waddr = wr_req_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
         mem_wdata = wr_req_data[w_wr_idx*DATA_WIDTH +: DATA_WIDTH];
         mem_wstrb = wr_req_strb[w_wr_idx*STRB_WIDTH +: STRB_WIDTH];
      end
   end

   // remember who was granted a read so the next-cycle data is steered back
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_pend <= 1'b0;
         r_rsp_id   <= '0;
      end else begin
         r_rsp_pend <= |rd_req_ready;
         if (|rd_req_ready) r_rsp_id <= w_rd_idx;
      end
   end

   // response strobe; rst gates it so a response pending across reset is dropped immediately
   always_comb begin
      rd_rsp_valid = '0;
      if (r_rsp_pend && !rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_rsp_id == IW'(i)) rd_rsp_valid[i] = 1'b1;
         end
      end
   end

   assign rd_rsp_data = mem_rdata;

endmodule
